serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder that sits directly upstream of the team's 1-bit full adder cell (`full_add`). It drives that cell's `a`, `b` and `cin` inputs one bit per clock, LSB first, and consumes its `sum` and `cout` outputs. It captures operands on a start handshake, feeds the carry back through a flip-flop, assembles the result word, and signals completion. It trades WIDTH cycles of latency for a single full-adder cell.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_if.sv | 33 +++
 rtl/serial_adder_full_add.sv | 13 +
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Imported by the interface and by the top module.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; a 1- or 2-bit operand still needs one counter bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/response bundle for serial_adder. The master drives the operands;
// the adder (slave) returns status, the result and its FSM state for debug.
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  import serial_adder_pkg::*;

  // Handshake: a transfer happens on a rising clock edge where start=1 and
  // ready=1; a, b and cin are sampled only on that edge. start while ready=0
  // is ignored (no queuing). done is a one-cycle pulse marking the cycle in
  // which sum/cout first hold the new result; it needs no acknowledge.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  state_t           state;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, state
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, state
  );

endinterface

// File: rtl/serial_adder_full_add.sv
// The team's 1-bit full adder cell; purely combinational.
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held in a
// flop between bits. Result and carry-out are registered at completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  full_add u_full_add (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at r[0].
  generate
    if (WIDTH == 1) begin : g_r_single
      assign r_d = fa_sum;
    end else begin : g_r_multi
      assign r_d = {fa_sum, r_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            c_q     <= bus.cin;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          c_q   <= fa_cout;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            sum_q   <= r_d;
            cout_q  <= fa_cout;
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.state = state_q;

  // Status flags are a pure decode of the state register.
  a_busy_not_ready : assert property (@(posedge clk) disable iff (rst)
    busy_q == !ready_q);
  a_done_only_in_done : assert property (@(posedge clk) disable iff (rst)
    done_q == (state_q == ST_DONE));

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder at WIDTH=8 and WIDTH=1; expected results
// come from plain integer addition of the issued operands.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(1)) b1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model / scoreboard ----------------
  logic [8:0] exp8_q[$];
  logic [1:0] exp1_q[$];
  int         done_cnt8 = 0;
  int         done_cnt1 = 0;
  logic [8:0] last8 = '0;
  logic [1:0] last1 = '0;

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    return 9'(a) + 9'(b) + 9'(ci);
  endfunction

  function automatic logic [1:0] model1(input logic a, input logic b, input logic ci);
    return 2'(a) + 2'(b) + 2'(ci);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst) begin
      last8 = '0;
    end else begin
      check("ready8_vs_busy8", 32'(b8.ready), 32'(!b8.busy));
      if (b8.done) begin
        done_cnt8++;
        if (exp8_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done8_unexpected: got done with result 0x%0h, expected no done", {b8.cout, b8.sum});
        end else begin
          check("result8", 32'({b8.cout, b8.sum}), 32'(exp8_q.pop_front()));
        end
        last8 = {b8.cout, b8.sum};
      end else begin
        check("hold8", 32'({b8.cout, b8.sum}), 32'(last8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      last1 = '0;
    end else begin
      check("ready1_vs_busy1", 32'(b1.ready), 32'(!b1.busy));
      if (b1.done) begin
        done_cnt1++;
        if (exp1_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done1_unexpected: got done with result 0x%0h, expected no done", {b1.cout, b1.sum});
        end else begin
          check("result1", 32'({b1.cout, b1.sum}), 32'(exp1_q.pop_front()));
        end
        last1 = {b1.cout, b1.sum};
      end else begin
        check("hold1", 32'({b1.cout, b1.sum}), 32'(last1));
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_ready8();
    for (int i = 0; i < 40; i++) begin
      if (b8.ready) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL wait_ready8: ready still 0 after 40 cycles, expected 1");
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    wait_ready8();
    b8.start = 1'b1;
    b8.a     = a;
    b8.b     = b;
    b8.cin   = ci;
    exp8_q.push_back(model8(a, b, ci));
    @(negedge clk);
    b8.start = 1'b0;
    b8.a     = 8'($urandom);
    b8.b     = 8'($urandom);
    b8.cin   = 1'($urandom);
  endtask

  task automatic wait_done8(output int busy_cnt, output int cyc);
    busy_cnt = 0;
    cyc      = 0;
    while (!b8.done && cyc < 40) begin
      if (b8.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (!b8.done) begin
      checks++;
      failures++;
      $display("FAIL wait_done8: no done after %0d cycles, expected done", cyc);
    end
  endtask

  task automatic issue1(input logic a, input logic b, input logic ci);
    for (int i = 0; i < 10 && !b1.ready; i++) @(negedge clk);
    b1.start = 1'b1;
    b1.a     = a;
    b1.b     = b;
    b1.cin   = ci;
    exp1_q.push_back(model1(a, b, ci));
    @(negedge clk);
    b1.start = 1'b0;
    b1.a     = 1'($urandom);
    b1.b     = 1'($urandom);
    b1.cin   = 1'($urandom);
  endtask

  task automatic wait_done1(output int busy_cnt, output int cyc);
    busy_cnt = 0;
    cyc      = 0;
    while (!b1.done && cyc < 10) begin
      if (b1.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (!b1.done) begin
      checks++;
      failures++;
      $display("FAIL wait_done1: no done after %0d cycles, expected done", cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready8"}, 32'(b8.ready), 32'd1);
    check({tag, "_busy8"},  32'(b8.busy),  32'd0);
    check({tag, "_done8"},  32'(b8.done),  32'd0);
    check({tag, "_sum8"},   32'(b8.sum),   32'd0);
    check({tag, "_cout8"},  32'(b8.cout),  32'd0);
    check({tag, "_ready1"}, 32'(b1.ready), 32'd1);
    check({tag, "_sum1"},   32'(b1.sum),   32'd0);
    check({tag, "_cout1"},  32'(b1.cout),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc, cy, n;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
    b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Basic add with latency and busy-length checks
    issue8(8'h5A, 8'h3C, 1'b0);
    check("busy_during_shift", 32'(b8.busy), 32'd1);
    check("ready_during_shift", 32'(b8.ready), 32'd0);
    wait_done8(bc, cy);
    check("busy_cycles_w8", 32'(bc), 32'd8);
    check("latency_w8", 32'(cy), 32'd8);
    check("sum_5a_3c", 32'(b8.sum), 32'h96);
    check("cout_5a_3c", 32'(b8.cout), 32'd0);
    check("ready_in_done", 32'(b8.ready), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(b8.done), 32'd0);
    check("ready_after_done", 32'(b8.ready), 32'd1);

    // Carry boundaries
    issue8(8'hFF, 8'h01, 1'b0);
    wait_done8(bc, cy);
    check("sum_ff_01", 32'(b8.sum), 32'h00);
    check("cout_ff_01", 32'(b8.cout), 32'd1);
    issue8(8'hFF, 8'hFF, 1'b1);
    wait_done8(bc, cy);
    check("sum_ff_ff_1", 32'(b8.sum), 32'hFF);
    check("cout_ff_ff_1", 32'(b8.cout), 32'd1);
    repeat (2) @(negedge clk);

    // start during SHIFT is ignored
    n = done_cnt8;
    issue8(8'h11, 8'h22, 1'b0);
    repeat (2) @(negedge clk);
    b8.start = 1'b1; b8.a = 8'hAA; b8.b = 8'h55; b8.cin = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    wait_done8(bc, cy);
    check("sum_ignored_start", 32'(b8.sum), 32'h33);
    repeat (12) @(negedge clk);
    check("single_done_after_ignore", 32'(done_cnt8 - n), 32'd1);
    check("idle_after_ignore", 32'(b8.busy), 32'd0);

    // Back-to-back with start held high across DONE
    wait_ready8();
    b8.start = 1'b1; b8.a = 8'h01; b8.b = 8'h02; b8.cin = 1'b0;
    exp8_q.push_back(model8(8'h01, 8'h02, 1'b0));
    @(negedge clk);
    b8.a = 8'h10; b8.b = 8'h20;
    exp8_q.push_back(model8(8'h10, 8'h20, 1'b0));
    wait_done8(bc, cy);
    check("b2b_first_sum", 32'(b8.sum), 32'h03);
    @(negedge clk);
    b8.start = 1'b0;
    check("b2b_no_bubble", 32'(b8.busy), 32'd1);
    wait_done8(bc, cy);
    check("b2b_done_gap", 32'(cy + 1), 32'd9);
    check("b2b_second_sum", 32'(b8.sum), 32'h30);
    @(negedge clk);

    // Asynchronous reset mid-SHIFT
    issue8(8'h33, 8'h44, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async");
    exp8_q.delete();
    exp1_q.delete();
    n = done_cnt8;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (12) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt8 - n), 32'd0);
    issue8(8'h07, 8'h01, 1'b0);
    wait_done8(bc, cy);
    check("sum_after_reset", 32'(b8.sum), 32'h08);
    @(negedge clk);

    // WIDTH=1 instance
    issue1(1'b1, 1'b1, 1'b1);
    wait_done1(bc, cy);
    check("busy_cycles_w1", 32'(bc), 32'd1);
    check("sum_w1", 32'(b1.sum), 32'd1);
    check("cout_w1", 32'(b1.cout), 32'd1);
    for (int i = 0; i < 8; i++) begin
      issue1(1'($urandom), 1'($urandom), 1'($urandom));
      wait_done1(bc, cy);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    // Random traffic; zero-gap iterations exercise back-to-back accepts
    for (int i = 0; i < 40; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8(bc, cy);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    check("queue8_drained", 32'(exp8_q.size()), 32'd0);
    check("queue1_drained", 32'(exp1_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
